// File: rtl/game_ctrl_pkg.sv
// Shared game constants: FSM state encodings and default map addresses.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StPlay  = 3'd2,
    StHit   = 3'd3,
    StWin   = 3'd4,
    StLose  = 3'd5
  } state_e;

  localparam int unsigned START_IDX_DEF   = 40;
  localparam int unsigned WIN_IDX_DEF     = 56;
  localparam int unsigned FAIL_IDX_DEF    = 64;
  localparam int unsigned LIVES_DEF       = 3;
  localparam int unsigned READY_TICKS_DEF = 4;

  // A game result (finish or fail image) is on screen.
  function automatic logic is_result(state_e s);
    return (s == StWin) || (s == StLose);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: registers the input once and flags a 0->1 change.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Previous-cycle sample of the input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: start/ready/play/hit/result flow, map address and lives.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned START_IDX   = START_IDX_DEF,
  parameter int unsigned WIN_IDX     = WIN_IDX_DEF,
  parameter int unsigned FAIL_IDX    = FAIL_IDX_DEF,
  parameter int unsigned LIVES       = LIVES_DEF,
  parameter int unsigned READY_TICKS = READY_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       coll,
  output logic [6:0] idx,
  output logic       play,
  output logic       player_init,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       done
);

  localparam logic [6:0] StartIdx  = 7'(START_IDX);
  localparam logic [6:0] WinIdx    = 7'(WIN_IDX);
  localparam logic [6:0] FailIdx   = 7'(FAIL_IDX);
  localparam logic [1:0] LivesInit = 2'(LIVES);
  localparam logic [3:0] ReadyLast = 4'(READY_TICKS - 1);

  state_e     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] cnt_q, cnt_d;
  logic       play_q, play_d;
  logic       pinit_q, pinit_d;
  logic       done_q, done_d;
  logic       start_rise;

  edge_rise u_start_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (start),
    .rise (start_rise)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= StartIdx;
      lives_q <= LivesInit;
      cnt_q   <= 4'd0;
      play_q  <= 1'b0;
      pinit_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      play_q  <= play_d;
      pinit_q <= pinit_d;
      done_q  <= done_d;
    end
  end

  // Next state, counters and next-cycle outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    pinit_d = 1'b0;

    case (state_q)
      StIdle: begin
        idx_d = StartIdx;
        if (start_rise) begin
          state_d = StReady;
          lives_d = LivesInit;
          pinit_d = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      StReady: begin
        idx_d = StartIdx;
        if (tick) begin
          if (cnt_q == ReadyLast) begin
            state_d = StPlay;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StPlay: begin
        // Collision wins over a same-cycle scroll tick.
        if (coll) begin
          state_d = StHit;
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
        end else if (tick) begin
          if (idx_q != 7'd0) begin
            idx_d = idx_q - 7'd1;
          end else begin
            state_d = StWin;
            idx_d   = WinIdx;
          end
        end
      end
      StHit: begin
        // lives_q already holds the decremented count.
        if (lives_q == 2'd0) begin
          state_d = StLose;
          idx_d   = FailIdx;
        end else begin
          state_d = StReady;
          idx_d   = StartIdx;
          pinit_d = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      StWin, StLose: begin
        idx_d = (state_q == StWin) ? WinIdx : FailIdx;
        if (state_q == StLose) begin
          lives_d = 2'd0;
        end
        if (start_rise) begin
          state_d = StIdle;
          idx_d   = StartIdx;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = StartIdx;
        lives_d = LivesInit;
        cnt_d   = 4'd0;
      end
    endcase

    play_d = (state_d == StPlay);
    done_d = is_result(state_d);
  end

  assign idx         = idx_q;
  assign play        = play_q;
  assign player_init = pinit_q;
  assign lives       = lives_q;
  assign state       = state_q;
  assign done        = done_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The parameter START_IDX SHALL default to 40 and gives the first map row address of the maze at game start.
REQ-002 The parameter WIN_IDX SHALL default to 56 and gives the map address of the finish image.
REQ-003 The parameter FAIL_IDX SHALL default to 64 and gives the map address of the fail image.
REQ-004 The parameter LIVES SHALL default to 3 and gives the lives loaded at each new game (legal range 1..3).
REQ-005 The parameter READY_TICKS SHALL default to 4 and gives the number of scroll ticks held before play starts (legal range 1..15).
REQ-006 clk  input  1  system clock; the block has one clock and all state is clocked on its rising edge.
REQ-007 rst  input  1  reset; asynchronous and active-low.
REQ-008 tick  input  1  scroll strobe; a one-cycle pulse synchronous to clk.
REQ-009 start  input  1  validated "0" key level; only its rising edge is used.
REQ-010 coll  input  1  sticky collision flag from the collision detector.
REQ-011 idx  output  7  current map base address sent to the row generator.
REQ-012 play  output  1  enables player movement.
REQ-013 player_init  output  1  one-cycle pulse that re-seeds the player position and clears the collision flag.
REQ-014 lives  output  2  remaining lives.
REQ-015 state  output  3  current FSM state.
REQ-016 done  output  1  high while a game result is displayed.

Function
REQ-017 The FSM SHALL use these encodings: IDLE=0, READY=1, PLAY=2, HIT=3, WIN=4, LOSE=5.
REQ-018 The block SHALL detect start_rise as start AND NOT start_q, where start_q is start registered once; holding start SHALL NOT retrigger.
REQ-019 IDLE SHALL behave as follows:
- idx=START_IDX, play=0, done=0.
- On start_rise: go to READY, load lives=LIVES, pulse player_init for one cycle.
REQ-020 READY SHALL behave as follows:
- Hold idx=START_IDX and play=0.
- Count tick pulses; on the READY_TICKS-th tick, go to PLAY.
- Ignore coll.
REQ-021 PLAY SHALL behave as follows:
- play=1.
- On tick with idx>0: idx decrements by 1.
- On tick with idx==0: go to WIN.
REQ-022 In PLAY, coll=1 SHALL take priority over a tick in the same cycle: idx does not change and the next state is HIT.
REQ-023 HIT SHALL last exactly one cycle with play=0 and lives decremented by 1:
- If the pre-decrement lives was 1: go to LOSE.
- Otherwise: go to READY, set idx=START_IDX, pulse player_init.
REQ-024 WIN SHALL drive idx=WIN_IDX, done=1, play=0; LOSE SHALL drive idx=FAIL_IDX, done=1, play=0, lives=0.
REQ-025 In WIN or LOSE, start_rise SHALL return the FSM to IDLE with idx=START_IDX; a second start_rise is then required to begin a new game.
REQ-026 lives SHALL never wrap below 0 and SHALL never exceed LIVES.
REQ-027 All outputs SHALL be registered, with one-cycle latency from the triggering input edge.
REQ-028 Unused state encodings 6 and 7 SHALL recover to IDLE on the next clock.

Reset
REQ-029 While rst=0, the block SHALL immediately force:
- state=IDLE, idx=START_IDX, lives=LIVES
- play=0, player_init=0, done=0
- tick counter=0, start_q=0
REQ-030 Reset asserted mid-game (any state) SHALL abandon the game with no further player_init pulse.
REQ-031 Deassertion SHALL leave the block in IDLE waiting for start_rise.

Structure
REQ-032 The state encodings and the START_IDX, WIN_IDX and FAIL_IDX defaults SHALL live in the shared game constants package/include.
REQ-033 Rising-edge detection of start SHALL be a single sub-module, edge_rise, reused for tick qualification where needed.
REQ-034 The FSM, READY tick counter, idx down-counter and lives counter SHALL reside in game_ctrl.

Verification
REQ-035 Reset then start pulse -> player_init high 1 cycle, state=READY, lives=3; after 4 ticks state=PLAY, play=1.
REQ-036 PLAY with no coll, 41 ticks -> idx steps 40..0, then state=WIN, idx=56, done=1.
REQ-037 coll and tick asserted in the same cycle at idx=25 -> idx stays 25, HIT for 1 cycle, lives 3->2, READY with idx=40, player_init pulse.
REQ-038 Three collisions -> lives 3->2->1->0, state=LOSE, idx=64, done=1; start then held high for 100 cycles -> exactly one transition, to IDLE.
REQ-039 rst driven low during PLAY at idx=17 -> state=IDLE, idx=40, play=0 with no clock edge needed.
REQ-040 Force state to 7 -> IDLE on the next clock with all outputs at their reset values.
